// File: rtl/vram_frame_ctrl_pkg.sv
// Shared widths, state encoding and write payload for the double-buffered frame VRAM controller.
package vram_frame_ctrl_pkg;

    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned ROW_W      = 6;
    localparam int unsigned PIX_W      = 8;
    localparam int unsigned ROW_DATA_W = 512;
    localparam int unsigned NUM_PIX    = 4096;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CLEAR     = 2'd1,
        ST_SWAP_WAIT = 2'd2
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  data;
    } pix_wr_t;

endpackage

// File: rtl/vram_row_mux.sv
// Front-frame row-read capture: selects the front VRAM's row data on request and flags it valid next cycle.
module vram_row_mux
    import vram_frame_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_req,
    input  logic                  sel,
    input  logic [ROW_DATA_W-1:0] rd_data0,
    input  logic [ROW_DATA_W-1:0] rd_data1,
    output logic                  disp_valid,
    output logic [ROW_DATA_W-1:0] disp_data
);

    logic                  valid_q;
    logic [ROW_DATA_W-1:0] data_q;

    // Data is only captured on a request so it holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= rd_req;
            if (rd_req) begin
                data_q <= sel ? rd_data1 : rd_data0;
            end
        end
    end

    assign disp_valid = valid_q;
    assign disp_data  = data_q;

endmodule

// File: rtl/vram_frame_ctrl.sv
// Double-buffer controller: paint/clear writes go to the back frame, scanout reads the front frame,
// and front/back swaps commit only once no display read is in flight.
module vram_frame_ctrl
    import vram_frame_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [PIX_W-1:0]      wr_data,
    input  logic                  clear_req,
    input  logic [PIX_W-1:0]      clear_color,
    output logic                  clear_busy,
    output logic                  clear_done,
    input  logic                  swap_req,
    output logic                  swap_pending,
    output logic                  swap_done,
    output logic                  front_sel,
    input  logic                  disp_req,
    input  logic [ROW_W-1:0]      disp_row,
    output logic                  disp_valid,
    output logic [ROW_DATA_W-1:0] disp_data,
    output logic [ADDR_W-1:0]     vram_wr_addr,
    output logic [PIX_W-1:0]      vram_wr_data,
    output logic                  vram0_wr,
    output logic                  vram1_wr,
    output logic [ROW_W-1:0]      vram_rd_addr,
    output logic                  vram0_rd,
    output logic                  vram1_rd,
    input  logic [ROW_DATA_W-1:0] vram0_rd_data,
    input  logic [ROW_DATA_W-1:0] vram1_rd_data
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [PIX_W-1:0]  color_q, color_d;
    logic              swap_pending_q, swap_pending_d;
    logic              front_sel_q, front_sel_d;
    logic              clear_done_q, clear_done_d;
    logic              swap_done_q, swap_done_d;
    logic              rd_outstanding;
    logic              wr_back;
    pix_wr_t           wr_bus;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            color_q        <= '0;
            swap_pending_q <= 1'b0;
            front_sel_q    <= 1'b0;
            clear_done_q   <= 1'b0;
            swap_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            color_q        <= color_d;
            swap_pending_q <= swap_pending_d;
            front_sel_q    <= front_sel_d;
            clear_done_q   <= clear_done_d;
            swap_done_q    <= swap_done_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        color_d        = color_q;
        swap_pending_d = swap_pending_q;
        front_sel_d    = front_sel_q;
        clear_done_d   = 1'b0;
        swap_done_d    = 1'b0;
        wr_ready       = 1'b0;
        wr_back        = 1'b0;
        wr_bus         = '{addr: wr_addr, data: wr_data};

        unique case (state_q)
            ST_IDLE: begin
                wr_ready = !clear_req && !swap_req;
                wr_back  = wr_valid && wr_ready;
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    color_d = clear_color;
                    if (swap_req) begin
                        swap_pending_d = 1'b1;
                    end
                end else if (swap_req) begin
                    state_d        = ST_SWAP_WAIT;
                    swap_pending_d = 1'b1;
                end
            end
            ST_CLEAR: begin
                wr_back = 1'b1;
                wr_bus  = '{addr: cnt_q, data: color_q};
                if (swap_req) begin
                    swap_pending_d = 1'b1;
                end
                if (cnt_q == ADDR_W'(NUM_PIX - 1)) begin
                    cnt_d        = '0;
                    clear_done_d = 1'b1;
                    state_d      = (swap_pending_q || swap_req) ? ST_SWAP_WAIT : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            ST_SWAP_WAIT: begin
                // A row read issued last cycle still selects by the old front_sel.
                if (!disp_req && !rd_outstanding) begin
                    front_sel_d    = !front_sel_q;
                    swap_pending_d = 1'b0;
                    swap_done_d    = 1'b1;
                    state_d        = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign vram_wr_addr = wr_bus.addr;
    assign vram_wr_data = wr_bus.data;
    assign vram0_wr     = wr_back && front_sel_q;
    assign vram1_wr     = wr_back && !front_sel_q;

    assign vram_rd_addr = disp_row;
    assign vram0_rd     = disp_req && !front_sel_q;
    assign vram1_rd     = disp_req && front_sel_q;

    vram_row_mux u_row_mux (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_req     (disp_req),
        .sel        (front_sel_q),
        .rd_data0   (vram0_rd_data),
        .rd_data1   (vram1_rd_data),
        .disp_valid (disp_valid),
        .disp_data  (disp_data)
    );

    assign rd_outstanding = disp_valid;
    assign clear_busy     = (state_q == ST_CLEAR);
    assign clear_done     = clear_done_q;
    assign swap_done      = swap_done_q;
    assign swap_pending   = swap_pending_q;
    assign front_sel      = front_sel_q;

endmodule

// File: tb/tb_vram_frame_ctrl.sv
// Randomized self-checking bench for vram_frame_ctrl against a cycle-level behavioural model.
module tb_vram_frame_ctrl;
    import vram_frame_ctrl_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  wr_valid, wr_ready;
    logic [ADDR_W-1:0]     wr_addr;
    logic [PIX_W-1:0]      wr_data;
    logic                  clear_req, clear_busy, clear_done;
    logic [PIX_W-1:0]      clear_color;
    logic                  swap_req, swap_pending, swap_done, front_sel;
    logic                  disp_req, disp_valid;
    logic [ROW_W-1:0]      disp_row;
    logic [ROW_DATA_W-1:0] disp_data;
    logic [ADDR_W-1:0]     vram_wr_addr;
    logic [PIX_W-1:0]      vram_wr_data;
    logic                  vram0_wr, vram1_wr, vram0_rd, vram1_rd;
    logic [ROW_W-1:0]      vram_rd_addr;
    logic [ROW_DATA_W-1:0] vram0_rd_data, vram1_rd_data;

    always #5 clk = ~clk;

    vram_frame_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .clear_req     (clear_req),
        .clear_color   (clear_color),
        .clear_busy    (clear_busy),
        .clear_done    (clear_done),
        .swap_req      (swap_req),
        .swap_pending  (swap_pending),
        .swap_done     (swap_done),
        .front_sel     (front_sel),
        .disp_req      (disp_req),
        .disp_row      (disp_row),
        .disp_valid    (disp_valid),
        .disp_data     (disp_data),
        .vram_wr_addr  (vram_wr_addr),
        .vram_wr_data  (vram_wr_data),
        .vram0_wr      (vram0_wr),
        .vram1_wr      (vram1_wr),
        .vram_rd_addr  (vram_rd_addr),
        .vram0_rd      (vram0_rd),
        .vram1_rd      (vram1_rd),
        .vram0_rd_data (vram0_rd_data),
        .vram1_rd_data (vram1_rd_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: a clear is a countdown of remaining pixels; a swap is a pending flag.
    logic            m_front, m_pend, m_swapwait, m_prev_req;
    int              m_clear_left;
    logic [PIX_W-1:0] m_color;
    logic [511:0]    m_data;

    int   seen [NUM_PIX];
    int   n_cdone_obs, n_sdone_obs, cyc, cdone_cyc, sdone_cyc;
    logic last_ready;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        m_front = 0; m_pend = 0; m_swapwait = 0; m_prev_req = 0;
        m_clear_left = 0; m_color = '0; m_data = '0;
    endtask

    task automatic quiet_inputs();
        wr_valid = 0; wr_addr = '0; wr_data = '0;
        clear_req = 0; clear_color = '0; swap_req = 0;
        disp_req = 0; disp_row = '0;
    endtask

    task automatic check_reset_regs(input string tag);
        check(tag, 512'({front_sel, swap_pending, clear_busy, clear_done, swap_done, disp_valid}), 512'(0));
        check({tag, "_data"}, disp_data, 512'(0));
    endtask

    // One clock: called just after a negedge with inputs already applied.
    task automatic step();
        logic              exp_ready, exp_wr, cd, sd;
        logic [ADDR_W-1:0] ea, ga;
        logic [PIX_W-1:0]  ed, gd;
        #1;
        exp_ready = 0; exp_wr = 0; ea = '0; ed = '0;
        if (m_clear_left > 0) begin
            exp_wr = 1; ea = ADDR_W'(NUM_PIX - m_clear_left); ed = m_color;
        end else if (!m_swapwait) begin
            exp_ready = !clear_req && !swap_req;
            if (exp_ready && wr_valid) begin
                exp_wr = 1; ea = wr_addr; ed = wr_data;
            end
        end
        ga = exp_wr ? vram_wr_addr : '0;
        gd = exp_wr ? vram_wr_data : '0;
        check("comb", 512'({wr_ready, vram0_wr, vram1_wr, ga, gd, vram_rd_addr, vram0_rd, vram1_rd}),
              512'({exp_ready, exp_wr && m_front, exp_wr && !m_front, ea, ed, disp_row,
                    disp_req && !m_front, disp_req && m_front}));
        if (m_clear_left > 0 && (vram0_wr || vram1_wr)) seen[vram_wr_addr]++;
        last_ready = wr_ready;

        @(posedge clk);
        #1;
        cd = 0; sd = 0;
        if (disp_req) m_data = m_front ? vram1_rd_data : vram0_rd_data;
        if (m_clear_left > 0) begin
            if (swap_req) m_pend = 1;
            m_clear_left--;
            if (m_clear_left == 0) begin
                cd = 1;
                if (m_pend) m_swapwait = 1;
            end
        end else if (m_swapwait) begin
            if (!disp_req && !m_prev_req) begin
                m_front = !m_front; m_pend = 0; m_swapwait = 0; sd = 1;
            end
        end else if (clear_req) begin
            m_clear_left = NUM_PIX; m_color = clear_color;
            if (swap_req) m_pend = 1;
        end else if (swap_req) begin
            m_pend = 1; m_swapwait = 1;
        end
        m_prev_req = disp_req;
        check("regs", 512'({front_sel, swap_pending, clear_busy, clear_done, swap_done, disp_valid}),
              512'({m_front, m_pend, m_clear_left > 0, cd, sd, disp_req}));
        check("disp_data", disp_data, m_data);
        cyc++;
        if (clear_done) begin n_cdone_obs++; cdone_cyc = cyc; end
        if (swap_done)  begin n_sdone_obs++; sdone_cyc = cyc; end
        @(negedge clk);
    endtask

    initial begin
        int lo, bad, c0, s0;
        cyc = 0; n_cdone_obs = 0; n_sdone_obs = 0; cdone_cyc = 0; sdone_cyc = 0;
        rst_n = 0;
        quiet_inputs();
        vram0_rd_data = '0; vram1_rd_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_regs("reset");
        rst_n = 1;
        @(negedge clk);

        // Row read of the front frame.
        disp_req = 1; disp_row = 6'd3;
        vram0_rd_data = rnd512(); vram1_rd_data = ~vram0_rd_data;
        step();
        disp_req = 0;
        step();

        // Paint write lands in the back frame.
        wr_valid = 1; wr_addr = 12'h041; wr_data = 8'h5A;
        step();

        // Full clear with a write held pending.
        foreach (seen[i]) seen[i] = 0;
        c0 = n_cdone_obs;
        clear_req = 1; clear_color = 8'h00;
        step();
        clear_req = 0;
        lo = (last_ready == 1'b0) ? 1 : 0;
        for (int i = 0; i < 5000 && lo > 0; i++) begin
            wr_addr = ADDR_W'($urandom);
            step();
            if (last_ready) break;
            lo++;
        end
        check("clear_ready_low_cycles", 512'(lo), 512'(4097));
        bad = 0;
        foreach (seen[i]) if (seen[i] != 1) bad++;
        check("clear_cover", 512'(bad), 512'(0));
        check("clear_done_count", 512'(n_cdone_obs - c0), 512'(1));
        wr_valid = 0;

        // Swap while the display keeps reading.
        s0 = n_sdone_obs;
        disp_req = 1; swap_req = 1;
        for (int i = 0; i < 10; i++) begin
            disp_row = ROW_W'($urandom); vram0_rd_data = rnd512(); vram1_rd_data = rnd512();
            step();
            swap_req = 0;
        end
        check("swap_hold_front", 512'(front_sel), 512'(0));
        disp_req = 0;
        step();
        check("swap_not_yet", 512'(n_sdone_obs - s0), 512'(0));
        step();
        step();
        check("swap_committed", 512'({front_sel, n_sdone_obs - s0 == 1}), 512'(2'b11));
        disp_req = 1; vram1_rd_data = rnd512(); vram0_rd_data = rnd512();
        step();
        disp_req = 0;
        step();

        // Clear and swap requested together: clear first, then exactly one swap.
        c0 = n_cdone_obs; s0 = n_sdone_obs;
        clear_req = 1; swap_req = 1; clear_color = 8'hC3;
        step();
        clear_req = 0; swap_req = 0;
        for (int i = 0; i < 6000 && (n_sdone_obs == s0); i++) begin
            disp_req = $urandom_range(0, 3) == 0;
            swap_req = $urandom_range(0, 99) == 0;
            disp_row = ROW_W'($urandom); vram0_rd_data = rnd512(); vram1_rd_data = rnd512();
            step();
        end
        disp_req = 0; swap_req = 0;
        repeat (3) step();
        check("cs_counts", 512'({n_cdone_obs - c0, n_sdone_obs - s0}), 512'({32'd1, 32'd1}));
        check("cs_order", 512'(sdone_cyc > cdone_cyc), 512'(1));

        // Reset in the middle of a clear.
        c0 = n_cdone_obs;
        clear_req = 1; clear_color = 8'h77;
        step();
        clear_req = 0;
        repeat (1000) step();
        rst_n = 0;
        #1;
        model_reset();
        check_reset_regs("mid_clear_reset");
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (5) step();
        check("no_clear_done_after_reset", 512'(n_cdone_obs - c0), 512'(0));

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            wr_valid    = $urandom_range(0, 1) == 1;
            wr_addr     = ADDR_W'($urandom);
            wr_data     = PIX_W'($urandom);
            clear_req   = $urandom_range(0, 1499) == 0;
            clear_color = PIX_W'($urandom);
            swap_req    = $urandom_range(0, 29) == 0;
            disp_req    = $urandom_range(0, 1) == 1;
            disp_row    = ROW_W'($urandom);
            vram0_rd_data = rnd512(); vram1_rd_data = rnd512();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_frame_ctrl.md
Name: vram_frame_ctrl

Overview:
- Double-buffer controller for the two 4096-pixel, 8-bit frame VRAMs. Each VRAM has one pixel-write port and one 64-pixel, 512-bit row-read port with 1-cycle latency.
- Display scanout always reads the front frame. The paint writer and an internal clear engine write only the back frame.
- Front/back swaps are scheduled safely, and the 512-bit read data is returned with a valid flag.
- Sits between the GPU paint path, the display row fetcher and the VRAM frame instances.

Parameters:
- ADDR_W, 12, pixel address width (4096 pixels).
- ROW_W, 6, row address width (64 rows).
- PIX_W, 8, pixel width.
- ROW_DATA_W, 512, row-read width (64 x PIX_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  paint write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_addr  in  ADDR_W  back-frame pixel address.
- wr_data  in  PIX_W  pixel value.
- clear_req  in  1  pulse: fill back frame with clear_color.
- clear_color  in  PIX_W  fill value, sampled with clear_req.
- clear_busy  out  1  clear sweep in progress.
- clear_done  out  1  1-cycle pulse after the last clear write.
- swap_req  in  1  pulse: exchange front/back.
- swap_pending  out  1  swap requested, not yet committed.
- swap_done  out  1  1-cycle pulse on commit.
- front_sel  out  1  0: frame0 is front; 1: frame1 is front.
- disp_req  in  1  row read request.
- disp_row  in  ROW_W  row index.
- disp_valid  out  1  disp_data valid.
- disp_data  out  ROW_DATA_W  front-frame row; pixel 0 in bits [7:0].
- vram_wr_addr  out  ADDR_W  shared write address.
- vram_wr_data  out  PIX_W  shared write data.
- vram0_wr, vram1_wr  out  1  write strobes.
- vram_rd_addr  out  ROW_W  shared row address.
- vram0_rd, vram1_rd  out  1  read strobes.
- vram0_rd_data, vram1_rd_data  in  ROW_DATA_W  VRAM read data.

Behaviour:
- Reset values: front_sel=0, state IDLE, clear counter 0, swap_pending=0, disp_valid=0, disp_data=0, clear_busy=0, clear_done=0, swap_done=0.
  - Reset mid-clear or mid-swap aborts the operation. Partial clear contents remain; no pulse is emitted.
- Read path (combinational strobes):
  - vram_rd_addr=disp_row.
  - vram{front_sel}_rd=disp_req; the back-frame rd strobe is always 0.
  - Next cycle: disp_valid=1 and disp_data = selected rd_data, using front_sel registered at request time.
  - Latency is exactly 1 cycle. Back-to-back requests every cycle are allowed. disp_data holds when disp_valid=0.
  - rd_outstanding = registered disp_req.
- FSM states: IDLE, CLEAR, SWAP_WAIT.
  - IDLE: wr_ready = !clear_req && !swap_req.
    - On an accepted write: vram{~front_sel}_wr=1, vram_wr_addr=wr_addr, vram_wr_data=wr_data, same cycle.
    - clear_req goes to CLEAR and latches clear_color. If swap_req is also set in that cycle, swap_pending=1 is kept and the swap runs after the clear.
    - Otherwise swap_req goes to SWAP_WAIT with swap_pending=1.
  - CLEAR: wr_ready=0.
    - Each cycle writes the latched color to back-frame address cnt; cnt runs 0..4095.
    - At cnt=4095: clear_done pulses next cycle, and cnt wraps to 0.
    - Next state is SWAP_WAIT if swap_pending, else IDLE.
    - Total duration is 4096 cycles. clear_req is ignored here. swap_req sets swap_pending.
  - SWAP_WAIT: wr_ready=0.
    - Commits when !disp_req && !rd_outstanding: front_sel toggles, swap_pending clears, swap_done pulses next cycle, state returns to IDLE.
    - Waits indefinitely while the display is busy. Repeated swap_req while pending merges into one swap. clear_req here is ignored.
- The front frame is never written. At most one write strobe is active per cycle.

Decomposition:
- Shared package: state encoding (IDLE/CLEAR/SWAP_WAIT), ADDR_W/ROW_W/PIX_W/ROW_DATA_W defaults, NUM_PIX=4096.
- Sub-module vram_row_mux: registered 512-bit front-frame read mux plus disp_valid pipeline.
- FSM, clear counter and write muxing stay in the top level.

Test Plan:
- Reset, then disp_req row 3 with vram0_rd_data=pattern A -> vram0_rd=1, vram1_rd=0; next cycle disp_valid=1, disp_data=A.
- wr_valid addr 0x041 data 0x5A in IDLE -> wr_ready=1, vram1_wr=1 (front_sel=0), vram0_wr=0, same cycle.
- clear_req color 0x00 with wr_valid held -> wr_ready=0 for 4097 cycles; vram1_wr covers addresses 0..4095 exactly once; clear_done pulses once; then wr_ready=1.
- swap_req while disp_req is held high for 10 cycles -> swap_pending=1, front_sel stays 0; commit 2 cycles after disp_req drops; swap_done pulses; subsequent reads strobe vram1_rd.
- clear_req and swap_req in the same cycle -> full clear first, then swap; exactly one swap_done, after clear_done.
- rst_n asserted at clear cnt=1000 -> outputs return to reset values immediately; no clear_done; front_sel=0.
